ieee_adder_normalize_round: RTL and testbench

- Downstream stage of the single-precision adder/subtractor datapath.
- Consumes the raw sum: sign, larger biased exponent, and unnormalized significand (carry, hidden, fraction, 3 guard bits).
- Normalizes left or right, rounds to nearest-even, handles overflow, denormals and zero, and packs the IEEE-754 word.
- Two-stage pipeline with valid/ready handshake and full backpressure.

---
 rtl/ieee_adder_normalize_round.sv | 191 +++++++++++++++++++
 tb/tb_ieee_adder_normalize_round.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_adder_normalize_round.sv
// Normalize/round/pack stage of the single-precision adder.
// in_* raw sum (valid/ready) -> outputC + overflow/inexact (valid/ready), 2 regs.
module ieee_adder_normalize_round #(
  parameter int EXPO_LEN        = 8,
  parameter int SIGNIFICAND_LEN = 23,
  parameter int GUARDBITS       = 3
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_sign,
  input  logic [EXPO_LEN-1:0] in_exponent,
  input  logic [SIGNIFICAND_LEN+GUARDBITS+1:0] in_significand,
  output logic out_valid,
  input  logic out_ready,
  output logic [EXPO_LEN+SIGNIFICAND_LEN:0] outputC,
  output logic out_overflow,
  output logic out_inexact
);

  localparam int W   = SIGNIFICAND_LEN + GUARDBITS + 2;
  localparam int NW  = W - 1;
  localparam int EW  = EXPO_LEN + 1;
  localparam int RW  = SIGNIFICAND_LEN + 2;
  localparam int OW  = EXPO_LEN + SIGNIFICAND_LEN + 1;
  localparam int LZW = $clog2(NW + 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXPO_LEN) - 1);

  logic s2_adv;

  logic s1_valid_q, s1_valid_d;
  logic s1_sign_q, s1_sign_d;
  logic s1_byp_q, s1_byp_d;
  logic s1_zero_q, s1_zero_d;
  logic [EW-1:0] s1_exp_q, s1_exp_d;
  logic [NW-1:0] s1_sig_q, s1_sig_d;

  logic out_valid_q, out_valid_d;
  logic [OW-1:0] res_q, res_d;
  logic ovf_q, ovf_d;
  logic inx_q, inx_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  logic [EW-1:0] e_eff, e_m1, lz_e, shamt;
  logic [LZW-1:0] lz;
  logic [NW-1:0] shifted;
  logic is_byp, is_zero, is_carry, is_norm, is_sub;

  always_comb begin
    e_eff = (in_exponent == '0) ? EW'(1) : {1'b0, in_exponent};
    lz = LZW'(NW);
    for (int i = 0; i < NW; i++) begin
      if (in_significand[i]) lz = LZW'(NW - 1 - i);
    end
    lz_e  = EW'(lz);
    e_m1  = e_eff - EW'(1);
    // Never shift past the smallest normal exponent: the rest stays denormal.
    shamt = (lz_e < e_m1) ? lz_e : e_m1;
    shifted = in_significand[NW-1:0] << shamt;

    is_byp   = in_exponent == EMAX[EXPO_LEN-1:0];
    is_zero  = !is_byp && (in_significand == '0);
    is_carry = !is_byp && in_significand[W-1];
    is_norm  = !is_byp && !in_significand[W-1]
               && in_significand[NW-1];
    is_sub   = !is_byp && !is_zero && !in_significand[W-1]
               && !in_significand[NW-1];

    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_byp_d   = s1_byp_q;
    s1_zero_d  = s1_zero_q;
    s1_exp_d   = s1_exp_q;
    s1_sig_d   = s1_sig_q;

    if (in_valid && in_ready) begin
      s1_sign_d = in_sign;
      s1_byp_d  = is_byp;
      s1_zero_d = is_zero;
      unique case (1'b1)
        is_byp: begin
          s1_exp_d = EMAX;
          s1_sig_d = in_significand[NW-1:0];
        end
        is_zero: begin
          s1_exp_d = '0;
          s1_sig_d = '0;
        end
        is_carry: begin
          s1_exp_d = e_eff + EW'(1);
          s1_sig_d = {in_significand[W-1:2],
                      |in_significand[1:0]};
        end
        is_norm: begin
          s1_exp_d = e_eff;
          s1_sig_d = in_significand[NW-1:0];
        end
        is_sub: begin
          s1_sig_d = shifted;
          s1_exp_d = shifted[NW-1] ? e_eff - shamt : '0;
        end
        default: ;
      endcase
    end
  end

  logic [GUARDBITS-1:0] grs;
  logic inc;
  logic [RW-1:0] rsum;
  logic [EW-1:0] exp_r;
  logic [SIGNIFICAND_LEN-1:0] frac;

  always_comb begin
    grs  = s1_sig_q[GUARDBITS-1:0];
    inc  = grs[GUARDBITS-1]
           & ((|grs[GUARDBITS-2:0]) | s1_sig_q[GUARDBITS]);
    rsum = {1'b0, s1_sig_q[NW-1:GUARDBITS]} + RW'(inc);

    // Denormal that rounds up into the hidden bit becomes the smallest normal.
    if (s1_exp_q == '0) begin
      exp_r = rsum[SIGNIFICAND_LEN] ? EW'(1) : '0;
    end else if (rsum[RW-1]) begin
      exp_r = s1_exp_q + EW'(1);
    end else begin
      exp_r = s1_exp_q;
    end
    frac = rsum[RW-1] ? '0 : rsum[SIGNIFICAND_LEN-1:0];

    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    res_d = res_q;
    ovf_d = ovf_q;
    inx_d = inx_q;

    if (s1_valid_q && s2_adv) begin
      if (s1_byp_q) begin
        res_d = {s1_sign_q, EMAX[EXPO_LEN-1:0],
                 s1_sig_q[NW-2:GUARDBITS]};
        ovf_d = 1'b0;
        inx_d = 1'b0;
      end else if (s1_zero_q) begin
        res_d = '0;
        ovf_d = 1'b0;
        inx_d = 1'b0;
      end else if (exp_r >= EMAX) begin
        res_d = {s1_sign_q, EMAX[EXPO_LEN-1:0],
                 {SIGNIFICAND_LEN{1'b0}}};
        ovf_d = 1'b1;
        inx_d = 1'b1;
      end else begin
        res_d = {s1_sign_q, exp_r[EXPO_LEN-1:0], frac};
        ovf_d = 1'b0;
        inx_d = |grs;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sig_q    <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_byp_q    <= s1_byp_d;
      s1_zero_q   <= s1_zero_d;
      s1_exp_q    <= s1_exp_d;
      s1_sig_q    <= s1_sig_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      inx_q       <= inx_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign outputC      = res_q;
  assign out_overflow = ovf_q & out_valid_q;
  assign out_inexact  = inx_q & out_valid_q;

endmodule

// File: tb/tb_ieee_adder_normalize_round.sv
// Bench for ieee_adder_normalize_round: directed cases, backpressure,
// async reset and a randomized stream against a value-level model.
module tb_ieee_adder_normalize_round;

  logic clock_in = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, in_sign;
  logic [7:0] in_exponent;
  logic [27:0] in_significand;
  logic out_valid, out_ready;
  logic [31:0] outputC;
  logic out_overflow, out_inexact;

  int n_pass = 0;
  int n_total = 0;
  logic [33:0] exp_q[$];

  ieee_adder_normalize_round dut (
    .clock_in(clock_in), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent),
    .in_significand(in_significand),
    .out_valid(out_valid), .out_ready(out_ready),
    .outputC(outputC), .out_overflow(out_overflow),
    .out_inexact(out_inexact)
  );

  always #5 clock_in = ~clock_in;

  // Value-level model: result exponent from the MSB position, clamped at
  // the smallest normal, then round-to-nearest-even on the 3 low bits.
  function automatic logic [33:0] model(input logic sg,
      input logic [7:0] e, input logic [27:0] m);
    int ee, p, ex, fld;
    longint k, q, rem;
    logic [31:0] r;
    if (e == 8'hFF) return {2'b00, sg, 8'hFF, m[25:3]};
    if (m == 28'd0) return 34'd0;
    ee = (e == 8'd0) ? 1 : int'(e);
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    ex = ee + p - 26;
    if (ex < 1) ex = 1;
    if (ex > ee) k = longint'(m >> 1) | longint'(m[0]);
    else k = longint'(m) << (ee - ex);
    q = k >> 3;
    rem = k & 7;
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      ex = ex + 1;
    end
    fld = (q >= (longint'(1) << 23)) ? ex : 0;
    if (fld >= 255) return {2'b11, sg, 8'hFF, 23'd0};
    r = {sg, fld[7:0], q[22:0]};
    return {(rem != 0), 1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
      input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, expv);
  endtask

  // Called at a negedge with inputs set: scoreboard both handshakes,
  // then advance one clock to the next negedge.
  task automatic tick();
    logic [33:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", outputC, e[31:0]);
        chk("sb_ovf", 32'(out_overflow), 32'(e[32]));
        chk("sb_inx", 32'(out_inexact), 32'(e[33]));
      end
    end
    if (in_valid && in_ready)
      exp_q.push_back(model(in_sign, in_exponent, in_significand));
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  task automatic put(input logic sg, input logic [7:0] e,
      input logic [27:0] m);
    in_valid = 1'b1;
    in_sign = sg;
    in_exponent = e;
    in_significand = m;
  endtask

  task automatic directed(input string tag, input logic sg,
      input logic [7:0] e, input logic [27:0] m,
      input logic [31:0] r, input logic ov, input logic nx);
    out_ready = 1'b1;
    put(sg, e, m);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, outputC, r);
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(ov));
    chk({tag, "_inx"}, 32'(out_inexact), 32'(nx));
    tick();
  endtask

  initial begin
    logic [27:0] m;
    logic [7:0] e;
    int sel;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exponent = 8'd0;
    in_significand = 28'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputC", outputC, 32'd0);
    chk("rst_flags", {30'd0, out_overflow, out_inexact}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clock_in);

    directed("one_plus_one", 1'b0, 8'h7F, 28'h8000000,
             32'h40000000, 1'b0, 1'b0);
    directed("cancel", 1'b0, 8'h7F, 28'h0000008,
             32'h34000000, 1'b0, 1'b0);
    directed("rne_tie_even", 1'b0, 8'h7F, 28'h4000004,
             32'h3F800000, 1'b0, 1'b1);
    directed("rne_tie_odd", 1'b0, 8'h7F, 28'h400000C,
             32'h3F800002, 1'b0, 1'b1);
    directed("overflow", 1'b0, 8'hFE, 28'h8000000,
             32'h7F800000, 1'b1, 1'b1);
    directed("bypass_nan", 1'b1, 8'hFF, 28'h6000000,
             32'hFFC00000, 1'b0, 1'b0);
    directed("neg_zero", 1'b1, 8'h7F, 28'h0000000,
             32'h00000000, 1'b0, 1'b0);
    directed("denorm", 1'b0, 8'h01, 28'h2000000,
             32'h00400000, 1'b0, 1'b0);
    directed("denorm_round_up", 1'b0, 8'h01, 28'h3FFFFFC,
             32'h00800000, 1'b0, 1'b1);
    directed("carry_round_ovf", 1'b1, 8'hFD, 28'hFFFFFFF,
             32'hFF800000, 1'b1, 1'b1);

    // Backpressure: A and B fill both stages, C must be held off.
    out_ready = 1'b0;
    put(1'b0, 8'h7F, 28'h8000000);
    tick();
    put(1'b0, 8'h7F, 28'h400000C);
    tick();
    put(1'b0, 8'h7F, 28'h0000008);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_A", outputC, 32'h40000000);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled discards in-flight words.
    out_ready = 1'b0;
    put(1'b1, 8'h80, 28'h4800000);
    tick();
    put(1'b0, 8'h10, 28'h0123456);
    tick();
    in_valid = 1'b0;
    chk("stall_full", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_outputC", outputC, 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);

    // Randomized stream with random valid/ready.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'hFE;
        3: e = 8'hFD;
        4: e = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h02;
        default: e = 8'($urandom_range(1, 254));
      endcase
      m = 28'($urandom);
      m = m >> $urandom_range(0, 27);
      if ($urandom_range(0, 19) == 0) m = 28'd0;
      put(1'($urandom), e, m);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    tick();
    chk("rand_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
